// File: rtl/ribbon_note_tracker.sv
// Debounces ribbon zone samples into a committed note, queues note_on/note_off
// events in a 2-deep FIFO and drives a square-wave tone for the held note.
module ribbon_note_tracker #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int STABLE_N = 3,
    parameter int BASE_MHZ = 261_626
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_stb,
    input  logic [7:0] zone_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_on,
    output logic [3:0] ev_note,
    output logic [3:0] cur_note,
    output logic       tone_out
);

    // Half period in clk cycles for key zone k (equal temperament above BASE_MHZ).
    function automatic int hp_calc(input int k);
        real f;
        f = 2.0 * real'(BASE_MHZ) * (2.0 ** (real'(k - 1) / 12.0));
        return $rtoi(real'(CLK_HZ) * 1000.0 / f + 0.5);
    endfunction

    localparam int HP1 = hp_calc(1);
    localparam int TW  = (HP1 > 2) ? $clog2(HP1) : 1;
    localparam int CW  = $clog2(STABLE_N + 1);

    logic [TW-1:0] hp_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_hp
        if (g >= 1 && g <= 11) begin : g_key
            assign hp_tab[g] = TW'(hp_calc(g));
        end else begin : g_none
            assign hp_tab[g] = '0;
        end
    end

    // Events are {on, note[3:0]}; fifo slot 0 is the head.
    // Handshake: an event transfers on a cycle where ev_valid && ev_ready; while
    // ev_valid is high and ev_ready is low, ev_on/ev_note do not change.
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cur_note_q, cur_note_d;
    logic [4:0]    fifo_q [2];
    logic [4:0]    fifo_d [2];
    logic [1:0]    count_q, count_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tone_q, tone_d;

    logic [3:0] z;
    logic       pop;
    logic       commit;
    logic [1:0] need;
    logic [1:0] free;

    always_comb begin
        z          = (zone_in > 8'd11) ? 4'd11 : zone_in[3:0];
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        fifo_d     = fifo_q;
        count_d    = count_q;
        cur_note_d = cur_note_q;
        tcnt_d     = tcnt_q;
        tone_d     = tone_q;

        if (sample_stb) begin
            if (z == cand_q) begin
                if (cnt_q != CW'(STABLE_N)) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = z;
                cnt_d  = CW'(1);
            end
        end

        pop = (count_q != 2'd0) && ev_ready;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            count_d   = count_q - 2'd1;
        end

        // A note change needs off(old) and on(new); the slot freed by a pop counts.
        need   = ((cur_note_q != 4'd0) && (cand_d != 4'd0)) ? 2'd2 : 2'd1;
        free   = 2'd2 - count_d;
        commit = (cnt_d == CW'(STABLE_N)) && (cand_d != cur_note_q) && (free >= need);

        if (commit) begin
            cur_note_d = cand_d;
            if (cur_note_q != 4'd0) begin
                fifo_d[count_d[0]] = {1'b0, cur_note_q};
                count_d            = count_d + 2'd1;
            end
            if (cand_d != 4'd0) begin
                fifo_d[count_d[0]] = {1'b1, cand_d};
                count_d            = count_d + 2'd1;
            end
        end

        if ((cur_note_d != cur_note_q) || (cur_note_q == 4'd0)) begin
            tcnt_d = '0;
            tone_d = 1'b0;
        end else if (tcnt_q == hp_tab[cur_note_q] - 1'b1) begin
            tcnt_d = '0;
            tone_d = ~tone_q;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            cur_note_q <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= '0;
            tcnt_q     <= '0;
            tone_q     <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            cur_note_q <= cur_note_d;
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            tcnt_q     <= tcnt_d;
            tone_q     <= tone_d;
        end
    end

    assign ev_valid = (count_q != 2'd0);
    assign ev_on    = fifo_q[0][4];
    assign ev_note  = fifo_q[0][3:0];
    assign cur_note = cur_note_q;
    assign tone_out = tone_q;

endmodule

// File: tb/tb_ribbon_note_tracker.sv
// Directed and randomized bench for ribbon_note_tracker against a sample-history
// reference model with an expected-event queue.
module tb_ribbon_note_tracker;

    localparam int CLK_HZ   = 1_000_000;
    localparam int STABLE_N = 3;
    localparam int BASE_MHZ = 261_626;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_stb = 1'b0;
    logic [7:0] zone_in = 8'd0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic       ev_on;
    logic [3:0] ev_note;
    logic [3:0] cur_note;
    logic       tone_out;

    ribbon_note_tracker #(
        .CLK_HZ  (CLK_HZ),
        .STABLE_N(STABLE_N),
        .BASE_MHZ(BASE_MHZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_stb(sample_stb),
        .zone_in   (zone_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_on     (ev_on),
        .ev_note   (ev_note),
        .cur_note  (cur_note),
        .tone_out  (tone_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: recent clamped samples, committed note, expected events.
    int         hist [$];
    int         m_cur = 0;
    logic [4:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit hist_stable();
        if (hist.size() < STABLE_N) return 1'b0;
        for (int i = 0; i < STABLE_N; i++)
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_q.delete();
        m_cur = 0;
    endfunction

    // One clock cycle: drive, check FIFO head, advance the model, check state after the edge.
    task automatic cyc(input bit stb, input int zone, input bit rdy);
        int cand;
        int need;
        sample_stb = stb;
        zone_in    = 8'(zone);
        ev_ready   = rdy;
        chk("ev_valid", {31'd0, ev_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("ev_head", {27'd0, ev_on, ev_note}, {27'd0, exp_q[0]});
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (stb) begin
            hist.push_back(zone > 11 ? 11 : zone);
            if (hist.size() > STABLE_N) void'(hist.pop_front());
        end
        if (hist_stable()) begin
            cand = hist[hist.size() - 1];
            need = (m_cur != 0 ? 1 : 0) + (cand != 0 ? 1 : 0);
            if (cand != m_cur && (2 - exp_q.size()) >= need) begin
                if (m_cur != 0) exp_q.push_back({1'b0, 4'(m_cur)});
                if (cand != 0) exp_q.push_back({1'b1, 4'(cand)});
                m_cur = cand;
            end
        end
        @(posedge clk);
        #1;
        chk("cur_note", {28'd0, cur_note}, 32'(m_cur));
        if (m_cur == 0) chk("tone_idle", {31'd0, tone_out}, 32'd0);
    endtask

    task automatic strobe(input int zone, input bit rdy);
        cyc(1'b1, zone, rdy);
        cyc(1'b0, zone, rdy);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ev_valid"}, {31'd0, ev_valid}, 32'd0);
        chk({tag, "_ev_on"}, {31'd0, ev_on}, 32'd0);
        chk({tag, "_ev_note"}, {28'd0, ev_note}, 32'd0);
        chk({tag, "_cur_note"}, {28'd0, cur_note}, 32'd0);
        chk({tag, "_tone_out"}, {31'd0, tone_out}, 32'd0);
    endtask

    initial begin
        int  hp10;
        int  t;
        int  hold_zone;
        real f;

        f    = 2.0 * real'(BASE_MHZ) * (2.0 ** (9.0 / 12.0));
        hp10 = $rtoi(real'(CLK_HZ) * 1000.0 / f + 0.5);

        // Power-on reset
        #2;
        chk_all_zero("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Zone 10 held three strobes, consumer ready
        for (int i = 0; i < 3; i++) strobe(10, 1'b1);
        drain(2);
        chk("note10", {28'd0, cur_note}, 32'd10);

        // Tone half period for zone 10
        sample_stb = 1'b0;
        ev_ready   = 1'b0;
        t = 0;
        while (tone_out !== 1'b1 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("tone_rise_seen", 32'(t < 5000), 32'd1);
        t = 0;
        while (tone_out === 1'b1 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("tone_half_period", 32'((t >= hp10 - 1) && (t <= hp10 + 1)), 32'd1);

        // 10 -> 3 with consumer stalled, then release
        for (int i = 0; i < 3; i++) strobe(3, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0);
        chk("stall_valid", {31'd0, ev_valid}, 32'd1);
        chk("stall_head", {27'd0, ev_on, ev_note}, {27'd0, 1'b0, 4'd10});
        drain(3);

        // Bounce then settle on 4
        strobe(4, 1'b1);
        strobe(4, 1'b1);
        strobe(7, 1'b1);
        strobe(4, 1'b1);
        strobe(4, 1'b1);
        chk("bounce_hold", {28'd0, cur_note}, 32'd3);
        strobe(4, 1'b1);
        chk("bounce_commit", {28'd0, cur_note}, 32'd4);
        drain(3);

        // Full FIFO defers the commit to 6
        for (int i = 0; i < 3; i++) strobe(8, 1'b0);
        for (int i = 0; i < 3; i++) strobe(6, 1'b0);
        chk("deferred", {28'd0, cur_note}, 32'd8);
        drain(4);
        chk("deferred_commit", {28'd0, cur_note}, 32'd6);

        // Out-of-range zone clamps to 11; then release to idle
        for (int i = 0; i < 3; i++) strobe(200, 1'b1);
        chk("clamp11", {28'd0, cur_note}, 32'd11);
        for (int i = 0; i < 3; i++) strobe(0, 1'b1);
        chk("idle_again", {28'd0, cur_note}, 32'd0);
        drain(3);

        // Asynchronous reset mid-tone with an event pending
        for (int i = 0; i < 3; i++) strobe(5, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, 0, 1'b0);
        chk("pre_reset_note", {28'd0, cur_note}, 32'd5);
        chk("pre_reset_valid", {31'd0, ev_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized run against the model
        hold_zone = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                hold_zone = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 11) : $urandom_range(12, 255);
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 11) : hold_zone,
                ($urandom_range(0, 3) != 0));
        end
        drain(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
